pi_bcd_formatter: RTL and testbench
===================================

# pi_bcd_formatter

Sequential fixed-point-to-decimal formatter placed directly downstream of the pi series accumulator. It consumes the accumulator's unsigned 50-bit value, scaled by 2^48 (2 integer bits, 48 fraction bits). It emits 16 packed BCD digits (1 integer, 15 fractional, truncated) sized for a 64-bit LCD field. The conversion runs one decimal digit per clock using a start/busy/done handshake.

## Interface
Parameters:
- NBITS_IN, 50, input width.
- FRAC_BITS, 48, fraction bits; INT_BITS = NBITS_IN-FRAC_BITS must be ≤ 3 so the integer part is one decimal digit.
- NDIGITS, 16, total output digits; output width 4*NDIGITS.

Ports:
- clk_2, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, request conversion of value; sampled only in IDLE.
- value, input, NBITS_IN, unsigned fixed-point operand.
- busy, input-side status: output, 1, high while converting.
- done, output, 1, one-cycle pulse when bcd is updated.
- bcd, output, 4*NDIGITS, packed BCD; digit NDIGITS-1 (MSB nibble) is the integer digit.

## Operation
- States: IDLE, INT, FRAC, DONE.
- IDLE: if start=1, latch value into an operand register and clear the digit counter, then go to INT. Otherwise stay in IDLE.
- INT: integer digit = operand[NBITS_IN-1:FRAC_BITS]. Shift it into the work shift register. frac ← operand[FRAC_BITS-1:0]. Go to FRAC.
- FRAC: each cycle computes p = frac*10 at width FRAC_BITS+4.
  - digit = p[FRAC_BITS+3:FRAC_BITS]; this is always 0..9.
  - frac ← p[FRAC_BITS-1:0].
  - Shift digit into the work register, LSB side.
  - After NDIGITS-1 fractional digits, go to DONE.
- DONE: copy the work register to bcd, assert done, and return to IDLE.
- Digits are truncated; no rounding is applied.
- bcd changes only in DONE and holds the previous result during a conversion.
- start is ignored in INT, FRAC and DONE; there is no queuing.
- value is not required to be stable after the cycle in which start is sampled.
- reset (any state, including mid-conversion): next cycle state=IDLE, busy=0, done=0, bcd=0, work/operand registers=0.
- Simultaneous reset and start: reset wins and the start is dropped.

## Timing
- Reset values: busy=0, done=0, bcd=0.
- start sampled high in IDLE at edge E0:
  - INT occupies the cycle after E0.
  - FRAC occupies the following NDIGITS-1 cycles.
  - DONE follows; done=1 and the new bcd are visible NDIGITS+1 cycles after E0 (17 with defaults).
- busy=1 exactly in INT and FRAC (NDIGITS cycles); busy=0 in IDLE and DONE.
- done is high for exactly one cycle.
- A new start is first accepted in the IDLE cycle after DONE, giving a minimum start-to-start period of NDIGITS+2 cycles.
- The digit counter is $clog2(NDIGITS) bits and never wraps past NDIGITS-1.

## Structure
- Package pi_display_pkg holds:
  - the state enum (IDLE, INT, FRAC, DONE), 2 bits;
  - constants NBITS_IN, FRAC_BITS, NDIGITS;
  - a localparam for the BCD width.
- Sub-module bcd_digit_step: purely combinational.
  - Input: frac (FRAC_BITS).
  - Outputs: digit (4) and frac_next (FRAC_BITS).
  - Implements multiply-by-10 as (frac<<3)+(frac<<1).
- Top level: FSM, operand/work registers, digit counter, output register.

## Test plan
- value=50'h3243F6A8885A3 (pi), start pulse → done 17 cycles later, bcd=64'h3141592653589793, busy high for 16 cycles.
- value=1<<48 → bcd=64'h1000000000000000; value=1<<47 → bcd=64'h0500000000000000; value=0 → bcd=0.
- value=2^50-1 → bcd=64'h3999999999999996 (truncation, not rounding).
- start held high continuously: conversions repeat every 18 cycles. Changing value or pulsing start during busy has no effect on the running result.
- reset asserted in the 5th FRAC cycle → next cycle busy=0, done=0, bcd=0. A start after reset converts the pi value correctly.
- reset and start high in the same IDLE cycle → no conversion; busy stays 0.

Source files
------------

// File: rtl/pi_bcd_formatter_pkg.sv
// Shared types and constants for the pi display path: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (IDLE/INT/FRAC/DONE), NBITS_IN, FRAC_BITS, NDIGITS, BCD_W.
package pi_display_pkg;

    localparam int NBITS_IN  = 50;           // accumulator width, 2.48 unsigned fixed point
    localparam int FRAC_BITS = 48;
    localparam int NDIGITS   = 16;           // 1 integer + 15 fractional digits
    localparam int BCD_W     = 4 * NDIGITS;  // packed BCD field width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        FRAC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pi_bcd_formatter_if.sv
// Request/result bundle between the pi accumulator side and the BCD formatter.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the formatter is idle (busy/done report progress).
// Signals: start, value (request); busy, done, bcd (status/result). master = requester, slave = formatter.
interface pi_bcd_formatter_if #(
    parameter int NBITS_IN = pi_display_pkg::NBITS_IN,
    parameter int NDIGITS  = pi_display_pkg::NDIGITS
) ();

    logic                   start;
    logic [NBITS_IN-1:0]    value;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   bcd;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output bcd
    );

endinterface

// File: rtl/pi_bcd_formatter_digit_step.sv
// One decimal digit extraction step: multiply the fraction by 10, split off the integer nibble.
// Latency: combinational.
// Backpressure: none.
// Ports: frac (in, FRAC_BITS), digit (out, 4), frac_next (out, FRAC_BITS).
module bcd_digit_step #(
    parameter int FRAC_BITS = pi_display_pkg::FRAC_BITS
) (
    input  logic [FRAC_BITS-1:0] frac,
    output logic [3:0]           digit,
    output logic [FRAC_BITS-1:0] frac_next
);

    logic [FRAC_BITS+3:0] frac_ext;
    logic [FRAC_BITS+3:0] prod;

    // frac < 1.0, so frac*10 < 10.0 and the top nibble is always a valid BCD digit.
    assign frac_ext  = {4'b0000, frac};
    assign prod      = (frac_ext << 3) + (frac_ext << 1);
    assign digit     = prod[FRAC_BITS+3:FRAC_BITS];
    assign frac_next = prod[FRAC_BITS-1:0];

endmodule

// File: rtl/pi_bcd_formatter.sv
// Converts the 2.48 pi accumulator value into 16 truncated packed BCD digits, one digit per clock.
// Latency: done and new bcd appear NDIGITS+1 cycles after start is sampled; start-to-start >= NDIGITS+2.
// Backpressure: none; start is ignored unless idle, busy is high for the INT and FRAC cycles.
// Ports: clk_2, reset (sync, active-high), bus (slave: start/value in, busy/done/bcd out).
module pi_bcd_formatter #(
    parameter int NBITS_IN  = pi_display_pkg::NBITS_IN,
    parameter int FRAC_BITS = pi_display_pkg::FRAC_BITS,
    parameter int NDIGITS   = pi_display_pkg::NDIGITS
) (
    input  logic                 clk_2,
    input  logic                 reset,
    pi_bcd_formatter_if.slave    bus
);

    import pi_display_pkg::*;

    // Integer part must fit in one decimal digit (at most 3 integer bits).
    localparam int BCD_BITS = 4 * NDIGITS;
    localparam int CNT_W    = $clog2(NDIGITS);
    localparam logic [CNT_W-1:0] LAST_FRAC = CNT_W'(NDIGITS - 2);

    state_t                 state;
    logic [NBITS_IN-1:0]    operand;
    logic [FRAC_BITS-1:0]   frac_q;
    logic [BCD_BITS-1:0]    work;
    logic [CNT_W-1:0]       digit_cnt;
    logic                   busy_q;
    logic                   done_q;
    logic [BCD_BITS-1:0]    bcd_q;

    logic [3:0]             int_digit;
    logic [3:0]             step_digit;
    logic [FRAC_BITS-1:0]   step_frac;

    assign int_digit = 4'(operand[NBITS_IN-1:FRAC_BITS]);

    bcd_digit_step #(
        .FRAC_BITS (FRAC_BITS)
    ) u_step (
        .frac      (frac_q),
        .digit     (step_digit),
        .frac_next (step_frac)
    );

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state     <= IDLE;
            operand   <= '0;
            frac_q    <= '0;
            work      <= '0;
            digit_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        operand   <= bus.value;
                        digit_cnt <= '0;
                        busy_q    <= 1'b1;
                        state     <= INT;
                    end
                end
                INT: begin
                    work   <= {work[BCD_BITS-5:0], int_digit};
                    frac_q <= operand[FRAC_BITS-1:0];
                    state  <= FRAC;
                end
                FRAC: begin
                    // Digits enter on the LSB side, so the integer digit ends up in the MSB nibble.
                    work   <= {work[BCD_BITS-5:0], step_digit};
                    frac_q <= step_frac;
                    if (digit_cnt == LAST_FRAC) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        digit_cnt <= digit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bcd_q  <= work;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_pi_bcd_formatter.sv
// Directed bench for pi_bcd_formatter: known fixed-point values against hand-computed BCD strings.
// Latency: checks the start-to-done distance and the busy window of every conversion.
// Backpressure: covers start held high, start during busy, reset mid-conversion, reset with start.
module tb_pi_bcd_formatter;

    localparam logic [49:0] PI_VAL  = 50'h3243F6A8885A3;
    localparam logic [63:0] PI_BCD  = 64'h3141592653589793;

    logic clk_2 = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;
    logic [63:0] prev_bcd = '0;

    pi_bcd_formatter_if bif ();

    pi_bcd_formatter dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk_2 = ~clk_2;

    // Advance past one rising edge; outputs are then sampled and inputs driven 1ns later.
    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic convert(input string tag, input logic [49:0] v, input logic [63:0] exp);
        int lat;
        int bcnt;
        bif.value = v;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.value = ~v;     // operand must already be latched
        check({tag, "_hold"}, bif.bcd, prev_bcd);
        lat  = 0;
        bcnt = 0;
        while (bif.done !== 1'b1 && lat < 40) begin
            if (bif.busy === 1'b1) bcnt++;
            if (lat == 3) bif.start = 1'b1;   // ignored while busy
            if (lat == 4) bif.start = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd17);
        check({tag, "_busy"}, 64'(bcnt), 64'd16);
        check({tag, "_bcd"}, bif.bcd, exp);
        prev_bcd = exp;
        tick();
        check({tag, "_pulse"}, 64'(bif.done), 64'd0);
        check({tag, "_idle"}, 64'(bif.busy), 64'd0);
    endtask

    initial begin
        int n;
        int cnt;

        reset     = 1'b1;
        bif.start = 1'b0;
        bif.value = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 64'(bif.busy), 64'd0);
        check("rst_done", 64'(bif.done), 64'd0);
        check("rst_bcd", bif.bcd, 64'd0);

        convert("pi",    PI_VAL,          PI_BCD);
        convert("one",   50'd1 << 48,     64'h1000000000000000);
        convert("half",  50'd1 << 47,     64'h0500000000000000);
        convert("zero",  50'd0,           64'h0000000000000000);
        convert("ones",  {50{1'b1}},      64'h3999999999999996);

        // start held high: back-to-back conversions every 18 cycles; value wiggles mid-run.
        bif.value = PI_VAL;
        bif.start = 1'b1;
        tick();
        n = 0;
        while (bif.done !== 1'b1 && n < 40) begin
            if (n == 3) bif.value = '0;
            if (n == 8) bif.value = PI_VAL;
            tick();
            n++;
        end
        check("held_lat", 64'(n), 64'd17);
        check("held_bcd1", bif.bcd, PI_BCD);
        tick();
        n = 1;
        while (bif.done !== 1'b1 && n < 40) begin
            if (n == 5) bif.value = 50'd1 << 48;
            if (n == 12) bif.value = PI_VAL;
            tick();
            n++;
        end
        bif.start = 1'b0;
        check("held_period", 64'(n), 64'd18);
        check("held_bcd2", bif.bcd, PI_BCD);
        tick();
        check("held_stop", 64'(bif.busy), 64'd0);

        // reset during the 5th FRAC cycle
        bif.value = 50'd1 << 48;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        repeat (5) tick();
        check("mid_busy_pre", 64'(bif.busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy", 64'(bif.busy), 64'd0);
        check("mid_done", 64'(bif.done), 64'd0);
        check("mid_bcd", bif.bcd, 64'd0);
        prev_bcd = '0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bif.done === 1'b1 || bif.busy === 1'b1) cnt++;
            tick();
        end
        check("mid_quiet", 64'(cnt), 64'd0);
        convert("pi_after_rst", PI_VAL, PI_BCD);

        // reset and start together in IDLE: start dropped
        reset     = 1'b1;
        bif.start = 1'b1;
        bif.value = PI_VAL;
        tick();
        reset     = 1'b0;
        bif.start = 1'b0;
        check("rs_busy", 64'(bif.busy), 64'd0);
        check("rs_bcd", bif.bcd, 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bif.done === 1'b1 || bif.busy === 1'b1) cnt++;
            tick();
        end
        check("rs_quiet", 64'(cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
